// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage: FSM states, opcode encodings and pointer helpers.
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    S_ADDR  = 3'd0,
    S_OPC   = 3'd1,
    S_ARG   = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } fetch_state_t;

  // HALT is a one-byte opcode (bit 7 clear)
  localparam logic [7:0] OP_HALT  = 8'h7F;
  localparam int         OPND_BIT = 7;

  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr);
    return ptr + 8'd1;
  endfunction

endpackage

// File: rtl/instr_fetch_op_len_dec.sv
// Opcode length/halt decoder, purely combinational; shared with the decode stage.
module op_len_dec
  import instr_fetch_pkg::*;
(
  input  logic [7:0] i_opcode,
  output logic       o_has_operand,
  output logic       o_is_halt
);

  assign o_has_operand = i_opcode[OPND_BIT];
  assign o_is_halt     = (i_opcode == OP_HALT);

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: reads opcode/operand from a synchronous ROM and presents them downstream
// over a ready/free handshake; supports jump redirects and HALT.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [7:0] RESET_VEC = 8'h00,
  parameter bit         HALT_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       arst,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic       jmp_en,
  input  logic [7:0] jmp_addr,
  output logic [7:0] PC_,
  output logic [7:0] IR_,
  output logic [7:0] IBR_,
  output logic       rdy_next,
  input  logic       free_next,
  output logic       halted
);

  fetch_state_t r_state;
  logic [7:0]   r_fptr;
  logic [7:0]   r_pc;
  logic [7:0]   r_ir;
  logic [7:0]   r_ibr;
  logic         r_rdy;
  logic         r_halted;

  logic [7:0]   w_dec_op;
  logic         w_has_operand;
  logic         w_is_halt;
  logic         w_xfer;
  logic         w_halt_stop;

  // In S_VALID the presented opcode is examined for HALT; otherwise the fresh ROM byte.
  assign w_dec_op = (r_state == S_VALID) ? r_ir : rom_data;

  op_len_dec u_op_len_dec (
    .i_opcode      (w_dec_op),
    .o_has_operand (w_has_operand),
    .o_is_halt     (w_is_halt)
  );

  assign w_xfer      = r_rdy && free_next;
  assign w_halt_stop = HALT_EN && w_is_halt;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state  <= S_ADDR;
      r_fptr   <= RESET_VEC;
      r_pc     <= 8'h00;
      r_ir     <= 8'h00;
      r_ibr    <= 8'h00;
      r_rdy    <= 1'b0;
      r_halted <= 1'b0;
    end else if (jmp_en) begin
      // Redirect: presented fields are left as-is; a coincident transfer has already happened.
      r_state  <= S_ADDR;
      r_fptr   <= jmp_addr;
      r_rdy    <= 1'b0;
      r_halted <= 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          r_fptr  <= ptr_inc(r_fptr);
          r_state <= S_OPC;
        end
        S_OPC: begin
          r_ir <= rom_data;
          if (w_has_operand) begin
            r_fptr  <= ptr_inc(r_fptr);
            r_state <= S_ARG;
          end else begin
            r_ibr   <= 8'h00;
            r_pc    <= r_fptr;
            r_rdy   <= 1'b1;
            r_state <= S_VALID;
          end
        end
        S_ARG: begin
          r_ibr   <= rom_data;
          r_pc    <= r_fptr;
          r_rdy   <= 1'b1;
          r_state <= S_VALID;
        end
        S_VALID: begin
          // rom_addr sits on fptr here, so the next opcode is already being read.
          if (w_xfer) begin
            r_rdy <= 1'b0;
            if (w_halt_stop) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else begin
              r_fptr  <= ptr_inc(r_fptr);
              r_state <= S_OPC;
            end
          end
        end
        S_HALT: begin
          r_rdy <= 1'b0;
        end
        default: begin
          r_state <= S_ADDR;
          r_rdy   <= 1'b0;
        end
      endcase
    end
  end

  assign rom_addr = r_fptr;
  assign PC_      = r_pc;
  assign IR_      = r_ir;
  assign IBR_     = r_ibr;
  assign rdy_next = r_rdy;
  assign halted   = r_halted;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural synchronous ROM.
module tb_instr_fetch;

  logic       clk;
  logic       arst;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       jmp_en;
  logic [7:0] jmp_addr;
  logic [7:0] PC_;
  logic [7:0] IR_;
  logic [7:0] IBR_;
  logic       rdy_next;
  logic       free_next;
  logic       halted;

  logic [7:0] rom [256];
  int         n_tests;
  int         n_fail;
  int         n_edges;

  instr_fetch #(
    .RESET_VEC (8'h00),
    .HALT_EN   (1'b1)
  ) dut (
    .clk       (clk),
    .arst      (arst),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .jmp_en    (jmp_en),
    .jmp_addr  (jmp_addr),
    .PC_       (PC_),
    .IR_       (IR_),
    .IBR_      (IBR_),
    .rdy_next  (rdy_next),
    .free_next (free_next),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Advance edges until rdy_next is seen (at least one edge), bounded.
  task automatic run_to_rdy(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!rdy_next && n < limit);
    check("rdy_timeout", {31'd0, rdy_next}, 32'd1);
  endtask

  task automatic jump(input logic [7:0] addr);
    jmp_en   = 1'b1;
    jmp_addr = addr;
    step();
    jmp_en   = 1'b0;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    arst      = 1'b1;
    jmp_en    = 1'b0;
    jmp_addr  = 8'h00;
    free_next = 1'b1;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;

    // T1: one-byte instruction after reset
    rom[0] = 8'h01;
    rom[1] = 8'h02;
    step();
    step();
    arst = 1'b0;
    check("rst_rdy",    {31'd0, rdy_next}, 32'd0);
    check("rst_pc",     {24'd0, PC_},      32'h00);
    check("rst_ir",     {24'd0, IR_},      32'h00);
    check("rst_ibr",    {24'd0, IBR_},     32'h00);
    check("rst_halted", {31'd0, halted},   32'd0);
    check("rst_addr",   {24'd0, rom_addr}, 32'h00);
    run_to_rdy(20, n_edges);
    check("t1_lat", n_edges,          32'd2);
    check("t1_ir",  {24'd0, IR_},     32'h01);
    check("t1_ibr", {24'd0, IBR_},    32'h00);
    check("t1_pc",  {24'd0, PC_},     32'h01);
    run_to_rdy(20, n_edges);
    check("t1_rate", n_edges,         32'd2);
    check("t1b_ir",  {24'd0, IR_},    32'h02);
    check("t1b_pc",  {24'd0, PC_},    32'h02);

    // T2: two-byte instruction
    rom[0] = 8'h85;
    rom[1] = 8'h3C;
    rom[2] = 8'h07;
    arst = 1'b1;
    step();
    arst = 1'b0;
    run_to_rdy(20, n_edges);
    check("t2_lat",  n_edges,          32'd3);
    check("t2_ir",   {24'd0, IR_},     32'h85);
    check("t2_ibr",  {24'd0, IBR_},    32'h3C);
    check("t2_pc",   {24'd0, PC_},     32'h02);
    check("t2_addr", {24'd0, rom_addr}, 32'h02);

    // T3: downstream stall holds everything
    free_next = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_rdy",  {31'd0, rdy_next}, 32'd1);
      check("t3_ir",   {24'd0, IR_},      32'h85);
      check("t3_pc",   {24'd0, PC_},      32'h02);
      check("t3_addr", {24'd0, rom_addr}, 32'h02);
    end
    free_next = 1'b1;
    run_to_rdy(20, n_edges);
    check("t3_lat", n_edges,      32'd2);
    check("t3_ir",  {24'd0, IR_}, 32'h07);
    check("t3_pc",  {24'd0, PC_}, 32'h03);

    // T4: redirect while presenting (coincident transfer)
    rom[8'h40] = 8'h90;
    rom[8'h41] = 8'h55;
    jump(8'h40);
    check("t4_rdy",  {31'd0, rdy_next}, 32'd0);
    check("t4_addr", {24'd0, rom_addr}, 32'h40);
    run_to_rdy(20, n_edges);
    check("t4_lat", n_edges,       32'd3);
    check("t4_ir",  {24'd0, IR_},  32'h90);
    check("t4_ibr", {24'd0, IBR_}, 32'h55);
    check("t4_pc",  {24'd0, PC_},  32'h42);

    // T5: two-byte instruction straddling the address wrap
    rom[8'hFF] = 8'hA1;
    rom[0]     = 8'h77;
    jump(8'hFF);
    run_to_rdy(20, n_edges);
    check("t5_lat", n_edges,       32'd3);
    check("t5_ir",  {24'd0, IR_},  32'hA1);
    check("t5_ibr", {24'd0, IBR_}, 32'h77);
    check("t5_pc",  {24'd0, PC_},  32'h01);

    // T6: HALT, resume by jump, reset in S_ARG with coincident jump
    rom[8'h10] = 8'h7F;
    jump(8'h10);
    run_to_rdy(20, n_edges);
    check("t6_lat", n_edges,      32'd2);
    check("t6_ir",  {24'd0, IR_}, 32'h7F);
    check("t6_pc",  {24'd0, PC_}, 32'h11);
    step();
    check("t6_rdy0", {31'd0, rdy_next}, 32'd0);
    check("t6_halt", {31'd0, halted},   32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_hold_rdy",  {31'd0, rdy_next}, 32'd0);
      check("t6_hold_halt", {31'd0, halted},   32'd1);
      check("t6_hold_addr", {24'd0, rom_addr}, 32'h11);
    end
    jump(8'h00);
    check("t6_unhalt", {31'd0, halted}, 32'd0);
    run_to_rdy(20, n_edges);
    check("t6_res_lat", n_edges,      32'd2);
    check("t6_res_ir",  {24'd0, IR_}, 32'h77);
    check("t6_res_pc",  {24'd0, PC_}, 32'h01);

    jump(8'h40);
    step();
    step();
    check("t6_arg_ir",  {24'd0, IR_},      32'h90);
    check("t6_arg_rdy", {31'd0, rdy_next}, 32'd0);
    arst     = 1'b1;
    jmp_en   = 1'b1;
    jmp_addr = 8'h40;
    step();
    arst   = 1'b0;
    jmp_en = 1'b0;
    check("t6_rst_ir",   {24'd0, IR_},      32'h00);
    check("t6_rst_pc",   {24'd0, PC_},      32'h00);
    check("t6_rst_ibr",  {24'd0, IBR_},     32'h00);
    check("t6_rst_rdy",  {31'd0, rdy_next}, 32'd0);
    check("t6_rst_addr", {24'd0, rom_addr}, 32'h00);
    run_to_rdy(20, n_edges);
    check("t6_ref_lat", n_edges,      32'd2);
    check("t6_ref_ir",  {24'd0, IR_}, 32'h77);
    check("t6_ref_pc",  {24'd0, PC_}, 32'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
